alu_cmd_seq: RTL and testbench

ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

---
 rtl/alu_cmd_seq.sv | 179 +++++++++++++++++
 tb/tb_alu_cmd_seq.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_seq.sv
// Command sequencer in front of a four-class ALU: issue, wait for a matching flag, return result.
// Optional statistics counters are enabled with macro ALU_CMD_SEQ_STATS_EN.
module alu_cmd_seq #(
  parameter int A_WIDTH = 16,
  parameter int B_WIDTH = 16,
  parameter int TIMEOUT = 4
) (
  input  logic                       CLK,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [3:0]                 cmd_func,
  input  logic [A_WIDTH-1:0]         cmd_a,
  input  logic [B_WIDTH-1:0]         cmd_b,
  output logic [A_WIDTH-1:0]         ALU_A,
  output logic [B_WIDTH-1:0]         ALU_B,
  output logic [3:0]                 ALU_FUNC,
  input  logic [A_WIDTH+B_WIDTH-1:0] Arith_OUT,
  input  logic [A_WIDTH+B_WIDTH-1:0] Logic_OUT,
  input  logic [A_WIDTH+B_WIDTH-1:0] CMP_OUT,
  input  logic [A_WIDTH+B_WIDTH-1:0] Shift_OUT,
  input  logic                       Carry_OUT,
  input  logic                       Arith_Flag,
  input  logic                       Logic_Flag,
  input  logic                       CMP_Flag,
  input  logic                       Shift_Flag,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [A_WIDTH+B_WIDTH-1:0] res_data,
  output logic                       res_carry,
  output logic [1:0]                 res_class,
  output logic                       res_err,
  output logic [15:0]                op_count,
  output logic [7:0]                 err_count
);

  localparam int RW = A_WIDTH + B_WIDTH;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            r_state;
  logic              r_cmd_ready;
  logic [A_WIDTH-1:0] r_alu_a;
  logic [B_WIDTH-1:0] r_alu_b;
  logic [3:0]        r_alu_func;
  logic [1:0]        r_cls;
  logic              r_dz;
  logic [CW-1:0]     r_wait_cnt;
  logic              r_res_valid;
  logic [RW-1:0]     r_res_data;
  logic              r_res_carry;
  logic [1:0]        r_res_class;
  logic              r_res_err;

  logic [3:0]        w_flags;
  logic [3:0]        w_exp;
  logic              w_hit;
  logic              w_last;
  logic              w_ok;
  logic              w_fin;
  logic              w_dz;
  logic [RW-1:0]     w_sel;

  assign w_flags = {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag};
  assign w_exp   = 4'b1000 >> r_cls;
  // First WAIT cycle (count 0) may see the previous op's flags.
  assign w_hit   = (w_flags == w_exp) && (r_wait_cnt != '0);
  assign w_last  = (r_wait_cnt == CW'(TIMEOUT - 1));
  assign w_ok    = !r_dz && w_hit;
  assign w_fin   = r_dz || w_hit || w_last;
  assign w_dz    = (cmd_func == 4'b0011) && (cmd_b == '0);

  always_comb begin
    w_sel = Arith_OUT;
    unique case (r_cls)
      2'd0: w_sel = Arith_OUT;
      2'd1: w_sel = Logic_OUT;
      2'd2: w_sel = CMP_OUT;
      2'd3: w_sel = Shift_OUT;
      default: w_sel = Arith_OUT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_func  <= '0;
      r_cls       <= '0;
      r_dz        <= 1'b0;
      r_wait_cnt  <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_carry <= 1'b0;
      r_res_class <= '0;
      r_res_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_wait_cnt  <= '0;
            r_cls       <= cmd_func[3:2];
            r_dz        <= w_dz;
            r_state     <= S_WAIT;
            if (!w_dz) begin
              r_alu_a    <= cmd_a;
              r_alu_b    <= cmd_b;
              r_alu_func <= cmd_func;
            end
          end
        end
        S_WAIT: begin
          if (w_fin) begin
            r_state     <= S_DONE;
            r_res_valid <= 1'b1;
            r_res_err   <= !w_ok;
            r_res_data  <= w_ok ? w_sel : '0;
            r_res_carry <= w_ok && (r_cls == 2'd0) && Carry_OUT;
            r_res_class <= r_cls;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign ALU_A     = r_alu_a;
  assign ALU_B     = r_alu_b;
  assign ALU_FUNC  = r_alu_func;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_carry = r_res_carry;
  assign res_class = r_res_class;
  assign res_err   = r_res_err;

`ifdef ALU_CMD_SEQ_STATS_EN
  logic [15:0] r_op_cnt;
  logic [7:0]  r_err_cnt;

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_op_cnt  <= '0;
      r_err_cnt <= '0;
    end else if (r_state == S_DONE && res_ready) begin
      if (r_op_cnt != 16'hFFFF) r_op_cnt <= r_op_cnt + 16'd1;
      if (r_res_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign op_count  = r_op_cnt;
  assign err_count = r_err_cnt;
`else
  assign op_count  = '0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Bench for alu_cmd_seq: behavioural ALU, transaction-level reference model,
// per-cycle compare and directed vectors with literal expectations.
module tb_alu_cmd_seq;
  localparam int AW = 16;
  localparam int BW = 16;
  localparam int RW = 32;
  localparam int TO = 4;
`ifdef ALU_CMD_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_func;
  logic [AW-1:0] cmd_a;
  logic [BW-1:0] cmd_b;
  logic [AW-1:0] ALU_A;
  logic [BW-1:0] ALU_B;
  logic [3:0]    ALU_FUNC;
  logic [RW-1:0] Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT;
  logic          Carry_OUT, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;
  logic          res_valid;
  logic          res_ready;
  logic [RW-1:0] res_data;
  logic          res_carry;
  logic [1:0]    res_class;
  logic          res_err;
  logic [15:0]   op_count;
  logic [7:0]    err_count;

  alu_cmd_seq #(.A_WIDTH(AW), .B_WIDTH(BW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_func(cmd_func),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUNC(ALU_FUNC),
    .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT), .CMP_OUT(CMP_OUT),
    .Shift_OUT(Shift_OUT), .Carry_OUT(Carry_OUT),
    .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag),
    .CMP_Flag(CMP_Flag), .Shift_Flag(Shift_Flag),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_carry(res_carry), .res_class(res_class), .res_err(res_err),
    .op_count(op_count), .err_count(err_count)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_data(input logic [3:0] f,
                                           input logic [15:0] a, b);
    logic [31:0] d;
    d = '0;
    case (f)
      4'h0: d = 32'(a) + 32'(b);
      4'h1: d = 32'(a) - 32'(b);
      4'h2: d = 32'(a) * 32'(b);
      4'h3: d = (b == 0) ? 32'd0 : 32'(a / b);
      4'h4: d = 32'(a & b);
      4'h5: d = 32'(a | b);
      4'h6: d = {16'h0, ~(a & b)};
      4'h7: d = {16'h0, ~(a | b)};
      4'h8: d = 32'd0;
      4'h9: d = (a == b) ? 32'd1 : 32'd0;
      4'hA: d = (a > b) ? 32'd2 : 32'd0;
      4'hB: d = (a < b) ? 32'd3 : 32'd0;
      4'hC: d = 32'(a >> 1);
      4'hD: d = 32'(a) << 1;
      4'hE: d = 32'(b >> 1);
      default: d = 32'(b) << 1;
    endcase
    return d;
  endfunction

  function automatic logic ref_carry(input logic [3:0] f,
                                     input logic [15:0] a, b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (f == 4'h0) return s[16];
    if (f == 4'h1) return a < b;
    return 1'b0;
  endfunction

  // Flag behaviour of the bench ALU: 0 normal, 1 none, 2 multi-hot, 3 wrong class.
  int fmode;
  int fdelay;
  int since;
  int m_phase;

  always_comb begin
    logic [1:0] cls;
    logic [3:0] oh;
    logic [3:0] fl;
    logic       on;
    cls = ALU_FUNC[3:2];
    oh  = 4'b1000 >> cls;
    on  = (since + 1) >= fdelay;
    fl  = 4'b0000;
    Arith_OUT = (cls == 2'd0) ? ref_data(ALU_FUNC, ALU_A, ALU_B)
                              : 32'hA0A0_0000 ^ 32'(ALU_A);
    Logic_OUT = (cls == 2'd1) ? ref_data(ALU_FUNC, ALU_A, ALU_B)
                              : 32'hB1B1_0000 ^ 32'(ALU_B);
    CMP_OUT   = (cls == 2'd2) ? ref_data(ALU_FUNC, ALU_A, ALU_B)
                              : 32'hC2C2_0007;
    Shift_OUT = (cls == 2'd3) ? ref_data(ALU_FUNC, ALU_A, ALU_B)
                              : 32'hD3D3_0009;
    Carry_OUT = (cls == 2'd0) ? ref_carry(ALU_FUNC, ALU_A, ALU_B) : 1'b1;
    case (fmode)
      0: fl = on ? oh : 4'b0000;
      1: fl = 4'b0000;
      2: fl = oh | {oh[0], oh[3:1]};
      default: fl = {oh[0], oh[3:1]};
    endcase
    {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag} = fl;
  end

  always @(posedge CLK) begin
    if (!rst && m_phase == 0 && cmd_valid) since <= 0;
    else if (since < 1000) since <= since + 1;
  end

  // Transaction-level reference: latency and result decided at acceptance.
  function automatic bit is_dz(input logic [3:0] f, input logic [15:0] b);
    return f == 4'h3 && b == 16'h0;
  endfunction

  function automatic int lat_of(input logic [3:0] f, input logic [15:0] b,
                                input int mode, input int d);
    int n;
    n = (d > 2) ? d : 2;
    if (is_dz(f, b)) return 1;
    if (mode == 0 && n <= TO) return n;
    return TO;
  endfunction

  function automatic bit ok_of(input logic [3:0] f, input logic [15:0] b,
                               input int mode, input int d);
    int n;
    n = (d > 2) ? d : 2;
    return !is_dz(f, b) && mode == 0 && n <= TO;
  endfunction

  int          m_rem;
  logic [31:0] m_pdata;
  logic        m_pcarry, m_perr;
  logic [1:0]  m_pcls;
  logic [15:0] e_a, e_b;
  logic [3:0]  e_f;
  logic [31:0] e_data;
  logic        e_carry, e_err;
  logic [1:0]  e_cls;
  int          e_ops, e_errs;

  always @(posedge CLK) begin
    if (rst) begin
      m_phase <= 0; m_rem <= 0;
      e_a <= '0; e_b <= '0; e_f <= '0;
      e_data <= '0; e_carry <= 1'b0; e_err <= 1'b0; e_cls <= '0;
      e_ops <= 0; e_errs <= 0;
    end else begin
      case (m_phase)
        0: if (cmd_valid) begin
          m_phase  <= 1;
          m_rem    <= lat_of(cmd_func, cmd_b, fmode, fdelay);
          m_perr   <= !ok_of(cmd_func, cmd_b, fmode, fdelay);
          m_pcls   <= cmd_func[3:2];
          m_pdata  <= ok_of(cmd_func, cmd_b, fmode, fdelay)
                      ? ref_data(cmd_func, cmd_a, cmd_b) : 32'd0;
          m_pcarry <= ok_of(cmd_func, cmd_b, fmode, fdelay)
                      && cmd_func[3:2] == 2'd0
                      && ref_carry(cmd_func, cmd_a, cmd_b);
          if (!is_dz(cmd_func, cmd_b)) begin
            e_a <= cmd_a; e_b <= cmd_b; e_f <= cmd_func;
          end
        end
        1: if (m_rem <= 1) begin
          m_phase <= 2;
          e_data <= m_pdata; e_carry <= m_pcarry;
          e_err <= m_perr; e_cls <= m_pcls;
        end else m_rem <= m_rem - 1;
        default: if (res_ready) begin
          m_phase <= 0;
          if (e_ops < 16'hFFFF) e_ops <= e_ops + 1;
          if (e_err && e_errs < 8'hFF) e_errs <= e_errs + 1;
        end
      endcase
    end
  end

  always @(negedge CLK) begin
    if (started) begin
      chk("cmd_ready", cmd_ready, m_phase == 0);
      chk("res_valid", res_valid, m_phase == 2);
      chk("ALU_A", ALU_A, e_a);
      chk("ALU_B", ALU_B, e_b);
      chk("ALU_FUNC", ALU_FUNC, e_f);
      chk("res_data", res_data, e_data);
      chk("res_carry", res_carry, e_carry);
      chk("res_class", res_class, e_cls);
      chk("res_err", res_err, e_err);
      chk("op_count", op_count, STATS ? e_ops : 0);
      chk("err_count", err_count, STATS ? e_errs : 0);
    end
  end

  task automatic run(input string nm, input logic [3:0] f,
                     input logic [15:0] a, b, input int mode, d, hold,
                     input bit junk, input int xlat, input logic [31:0] xdata,
                     input bit xcarry, input logic [1:0] xcls, input bit xerr);
    int lat;
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_func = f; cmd_a = a; cmd_b = b;
    fmode = mode; fdelay = d; res_ready = (hold == 0);
    @(posedge CLK);
    @(negedge CLK);
    if (junk) begin
      cmd_func = 4'h2; cmd_a = 16'h1234; cmd_b = 16'h0042;
    end else cmd_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(posedge CLK);
      @(negedge CLK);
      lat++;
    end
    cmd_valid = 1'b0;
    chk({nm, " latency"}, lat, xlat);
    chk({nm, " data"}, res_data, xdata);
    chk({nm, " carry"}, res_carry, xcarry);
    chk({nm, " class"}, res_class, xcls);
    chk({nm, " err"}, res_err, xerr);
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge CLK);
        @(negedge CLK);
        chk({nm, " held valid"}, res_valid, 1'b1);
        chk({nm, " held data"}, res_data, xdata);
        chk({nm, " held cmd_ready"}, cmd_ready, 1'b0);
      end
      res_ready = 1'b1;
    end
    @(posedge CLK);
    @(negedge CLK);
    res_ready = 1'b0;
    chk({nm, " ready after"}, cmd_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_func = '0; cmd_a = '0; cmd_b = '0;
    res_ready = 1'b0; fmode = 0; fdelay = 0; since = 0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    rst = 1'b0;
    chk("reset cmd_ready", cmd_ready, 1'b1);
    chk("reset res_valid", res_valid, 1'b0);
    chk("reset ALU_FUNC", ALU_FUNC, 4'h0);
    chk("reset res_data", res_data, 32'h0);
    started = 1'b1;

    run("add", 4'h0, 16'd15, 16'd5, 0, 0, 0, 0, 2, 32'd20, 0, 2'd0, 0);
    run("add carry", 4'h0, 16'hFFFF, 16'd1, 0, 0, 0, 0,
        2, 32'h10000, 1, 2'd0, 0);
    run("div0", 4'h3, 16'd15, 16'd0, 0, 0, 0, 0, 1, 32'd0, 0, 2'd0, 1);
    chk("div0 ALU_FUNC kept", ALU_FUNC, 4'h0);
    chk("div0 ALU_A kept", ALU_A, 16'hFFFF);
    run("timeout", 4'h5, 16'd15, 16'd5, 1, 0, 0, 0, 4, 32'd0, 0, 2'd1, 1);
    run("cmp hold", 4'hB, 16'd15, 16'd31, 0, 0, 5, 0, 2, 32'd3, 0, 2'd2, 0);
    run("or", 4'h5, 16'd15, 16'd5, 0, 0, 0, 0, 2, 32'd15, 0, 2'd1, 0);
    run("shl", 4'hD, 16'h8001, 16'd0, 0, 0, 0, 0,
        2, 32'h10002, 0, 2'd3, 0);
    run("multihot", 4'h7, 16'd3, 16'd4, 2, 0, 0, 0, 4, 32'd0, 0, 2'd1, 1);
    run("wrong cls", 4'h1, 16'd9, 16'd4, 3, 0, 1, 0, 4, 32'd0, 0, 2'd0, 1);
    run("mul late3", 4'h2, 16'd300, 16'd300, 0, 3, 0, 0,
        3, 32'd90000, 0, 2'd0, 0);
    run("and late4", 4'h4, 16'h00FF, 16'h0F0F, 0, 4, 2, 0,
        4, 32'h000F, 0, 2'd1, 0);
    run("nand late5", 4'h6, 16'd1, 16'd1, 0, 5, 0, 0, 4, 32'd0, 0, 2'd1, 1);
    run("nop", 4'h8, 16'd7, 16'd7, 0, 0, 0, 0, 2, 32'd0, 0, 2'd2, 0);
    run("div", 4'h3, 16'd100, 16'd7, 0, 0, 0, 0, 2, 32'd14, 0, 2'd0, 0);
    run("eq junk", 4'h9, 16'd42, 16'd42, 0, 0, 0, 1, 2, 32'd1, 0, 2'd2, 0);

    // Reset lands on the edge where the shift result would have appeared.
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_func = 4'hC; cmd_a = 16'h00F0; cmd_b = 16'h0;
    fmode = 0; fdelay = 0; res_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    cmd_valid = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    rst = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    rst = 1'b0;
    chk("rst res_valid", res_valid, 1'b0);
    chk("rst ALU_A", ALU_A, 16'h0);
    chk("rst ALU_FUNC", ALU_FUNC, 4'h0);
    chk("rst res_data", res_data, 32'h0);
    chk("rst res_class", res_class, 2'd0);
    chk("rst op_count", op_count, 16'h0);
    chk("rst cmd_ready", cmd_ready, 1'b1);
    repeat (4) begin
      @(posedge CLK);
      @(negedge CLK);
      chk("rst no result", res_valid, 1'b0);
    end
    res_ready = 1'b0;
    run("post rst", 4'h0, 16'd1, 16'd2, 0, 0, 0, 0, 2, 32'd3, 0, 2'd0, 0);

    repeat (2) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
